// File: rtl/polaris_bus_pkg.sv
// -----------------------------------------------------------------------------
// polaris_bus_pkg
// Shared definitions for the PolarisCPU bus arbiter:
//   bus_state_e        : arbiter grant state (IDLE / IGNT / DGNT)
//   SIZ_B..SIZ_D       : bus transfer size codes (byte, half, word, dword)
//   TIMEOUT_DEF        : default watchdog limit in granted cycles
// -----------------------------------------------------------------------------
package polaris_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } bus_state_e;

    localparam logic [1:0] SIZ_B = 2'd0;
    localparam logic [1:0] SIZ_H = 2'd1;
    localparam logic [1:0] SIZ_W = 2'd2;
    localparam logic [1:0] SIZ_D = 2'd3;

    localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/polaris_bus_wdt.sv
// -----------------------------------------------------------------------------
// polaris_bus_wdt
// Watchdog for a granted bus cycle. Counts granted cycles that see no
// acknowledge and flags the cycle in which the limit is reached.
// Ports:
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_clear  : restart the count (arbiter changes state)
//   i_run    : a master is currently granted
//   i_ack    : real bus acknowledge this cycle
//   o_expire : limit reached this cycle with no real acknowledge
// -----------------------------------------------------------------------------
module polaris_bus_wdt
    import polaris_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TW      = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    input  logic i_ack,
    output logic o_expire
);

    localparam logic [TW-1:0] LP_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run && !i_ack) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A real acknowledge in the expiry cycle takes precedence.
    assign o_expire = i_run & ~i_ack & (r_count == LP_LAST);

endmodule

// File: rtl/polaris_bus_arbiter.sv
// -----------------------------------------------------------------------------
// polaris_bus_arbiter
// Shares one 64-bit memory bus between the PolarisCPU instruction (I) and
// data (D) masters. D wins simultaneous requests; after an acknowledge the
// other master is granted if it is requesting, giving round-robin fairness.
// A watchdog forces completion of stalled cycles (ack with zero data, tmo_o).
// Ports:
//   clk_i, reset_i                    : clock, async active-low reset
//   iadr_i, isiz_i, iack_o, idat_o    : instruction fetch master
//   dadr_i, ddat_i, dwe_i, dcyc_i,
//   dstb_i, dsiz_i, dsigned_i,
//   dack_o, ddat_o                    : data master
//   madr_o, mdat_o, mwe_o, mcyc_o,
//   mstb_o, msiz_o, msigned_o,
//   mack_i, mdat_i                    : memory / IO bus
//   tmo_o                             : watchdog forced-completion pulse
// -----------------------------------------------------------------------------
module polaris_bus_arbiter
    import polaris_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TW      = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] iadr_i,
    input  logic [1:0]  isiz_i,
    output logic        iack_o,
    output logic [31:0] idat_o,
    input  logic [63:0] dadr_i,
    input  logic [63:0] ddat_i,
    input  logic        dwe_i,
    input  logic        dcyc_i,
    input  logic        dstb_i,
    input  logic [1:0]  dsiz_i,
    input  logic        dsigned_i,
    output logic        dack_o,
    output logic [63:0] ddat_o,
    output logic [63:0] madr_o,
    output logic [63:0] mdat_o,
    output logic        mwe_o,
    output logic        mcyc_o,
    output logic        mstb_o,
    output logic [1:0]  msiz_o,
    output logic        msigned_o,
    input  logic        mack_i,
    input  logic [63:0] mdat_i,
    output logic        tmo_o
);

    bus_state_e  r_state;
    bus_state_e  w_next;

    logic        w_ireq;
    logic        w_dreq;
    logic        w_granted;
    logic        w_own_req;
    logic        w_expire;
    logic        w_tmo;
    logic        w_done;
    logic        w_wdt_clear;
    logic [31:0] w_ihalf;

    assign w_ireq    = |isiz_i;
    assign w_dreq    = dcyc_i & dstb_i;
    assign w_granted = (r_state != IDLE);
    assign w_own_req = ((r_state == IGNT) & w_ireq) | ((r_state == DGNT) & w_dreq);

    // Forced completion only applies while the owner still requests;
    // a dropped request is an abandon, not a timeout.
    assign w_tmo   = w_expire & w_own_req;
    assign w_done  = w_own_req & (mack_i | w_expire);
    assign tmo_o   = w_tmo;

    // Little-endian 64-bit bus: address bit 2 selects the upper word.
    assign w_ihalf = iadr_i[2] ? mdat_i[63:32] : mdat_i[31:0];

    // Every state change (grant entry, completion, abandon) restarts the count.
    assign w_wdt_clear = (w_next != r_state);

    polaris_bus_wdt #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_wdt (
        .i_clk    (clk_i),
        .i_rst_n  (reset_i),
        .i_clear  (w_wdt_clear),
        .i_run    (w_granted),
        .i_ack    (mack_i),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        madr_o    = '0;
        mdat_o    = '0;
        mwe_o     = 1'b0;
        mcyc_o    = 1'b0;
        mstb_o    = 1'b0;
        msiz_o    = '0;
        msigned_o = 1'b0;
        iack_o    = 1'b0;
        dack_o    = 1'b0;
        idat_o    = '0;
        ddat_o    = '0;

        unique case (r_state)
            IDLE: begin
                if (w_dreq) begin
                    w_next = DGNT;
                end else if (w_ireq) begin
                    w_next = IGNT;
                end
            end

            IGNT: begin
                madr_o = iadr_i;
                msiz_o = isiz_i;
                mcyc_o = w_ireq;
                mstb_o = w_ireq;
                iack_o = w_done;
                idat_o = w_tmo ? '0 : w_ihalf;
                // The served master's request is stale in its ack cycle,
                // so only the other master may follow directly.
                if (!w_ireq) begin
                    w_next = IDLE;
                end else if (w_done) begin
                    w_next = w_dreq ? DGNT : IDLE;
                end
            end

            DGNT: begin
                madr_o    = dadr_i;
                mdat_o    = ddat_i;
                mwe_o     = dwe_i;
                msiz_o    = dsiz_i;
                msigned_o = dsigned_i;
                mcyc_o    = dcyc_i;
                mstb_o    = dstb_i;
                dack_o    = w_done;
                ddat_o    = w_tmo ? '0 : mdat_i;
                if (!w_dreq) begin
                    w_next = IDLE;
                end else if (w_done) begin
                    w_next = w_ireq ? IGNT : IDLE;
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/polaris_bus_arbiter.md
Name: polaris_bus_arbiter

Overview:
- Shares one 64-bit memory bus between the PolarisCPU instruction master (I port) and data master (D port).
- Sits between the CPU and the memory/IO fabric. Arbitrates the two requests, steers address, data and control from the granted master, and routes the acknowledge and read data back to it.
- Includes a watchdog that completes stalled cycles so the CPU cannot hang forever.

Parameters:
- TIMEOUT, 255, number of granted cycles without mack_i before a forced completion. Legal range 1..65535.
- TW, 8, width of the watchdog counter. Must hold TIMEOUT.

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- iadr_i  in  64  CPU fetch address.
- isiz_i  in  2  CPU fetch size. Nonzero means a fetch request (2'b10 = 32-bit).
- iack_o  out  1  fetch acknowledge to CPU.
- idat_o  out  32  fetch data to CPU.
- dadr_i  in  64  CPU data address.
- ddat_i  in  64  CPU store data.
- dwe_i  in  1  store enable.
- dcyc_i  in  1  data cycle.
- dstb_i  in  1  data strobe.
- dsiz_i  in  2  data size (0=byte, 1=half, 2=word, 3=dword).
- dsigned_i  in  1  sign-extend load.
- dack_o  out  1  data acknowledge to CPU.
- ddat_o  out  64  load data to CPU.
- madr_o  out  64  bus address.
- mdat_o  out  64  bus write data.
- mwe_o  out  1  bus write enable.
- mcyc_o  out  1  bus cycle.
- mstb_o  out  1  bus strobe.
- msiz_o  out  2  bus size.
- msigned_o  out  1  bus signed-load qualifier.
- mack_i  in  1  bus acknowledge.
- mdat_i  in  64  bus read data.
- tmo_o  out  1  one-cycle pulse when the watchdog forces a completion.

Behaviour:
- Request definitions: ireq = |isiz_i; dreq = dcyc_i & dstb_i.
- State machine: IDLE, IGNT, DGNT. State is registered; all bus outputs are combinational from state plus the granted master's inputs.
- Reset: asynchronous on reset_i low. State goes to IDLE, watchdog count to 0, tmo_o to 0. All m*_o, iack_o, dack_o, idat_o and ddat_o read 0 while in IDLE.
- Arbitration in IDLE:
  - dreq -> DGNT, else ireq -> IGNT, else stay IDLE. D wins simultaneous requests.
  - Grant latency: 1 clock from request to mcyc_o.
- In IGNT:
  - madr_o = iadr_i, msiz_o = isiz_i, mwe_o = 0, msigned_o = 0, mdat_o = 0.
  - mcyc_o = mstb_o = ireq.
- In DGNT:
  - madr_o = dadr_i, mdat_o = ddat_i, mwe_o = dwe_i, msiz_o = dsiz_i, msigned_o = dsigned_i.
  - mcyc_o = dcyc_i, mstb_o = dstb_i.
- Acknowledge routing (same cycle, combinational):
  - iack_o = mack_i & IGNT & ireq.
  - dack_o = mack_i & DGNT & dreq.
  - Never both set.
- Read data:
  - ddat_o = mdat_i while DGNT.
  - idat_o = iadr_i[2] ? mdat_i[63:32] : mdat_i[31:0] while IGNT. The bus is little-endian, 64-bit aligned.
- Completion: on the ack cycle, the next state is the other master's grant if that master is requesting, else IDLE.
  - The just-served master is never re-granted directly, because its request is stale in the ack cycle. This gives round-robin fairness under continuous load.
- Abandon: if the granted master drops its request without mack_i, mcyc_o falls the same cycle and state returns to IDLE next clock. No ack is issued.
- Watchdog:
  - Count clears on entry to a grant state and increments each granted cycle without mack_i.
  - When count == TIMEOUT-1 and mack_i is still 0: force the granted master's ack high for one cycle with data 0 and pulse tmo_o. The transition then proceeds exactly as for a normal ack.
  - mcyc_o drops in the following cycle.
  - A late mack_i arriving in IDLE is ignored.
- Simultaneous events: if mack_i and the timeout land in the same cycle, the real ack wins and tmo_o stays 0.
- Reset mid-transaction: the bus is released asynchronously (mcyc_o = 0 immediately). No ack is produced.

Decomposition:
- Package polaris_bus_pkg holds:
  - state encodings IDLE/IGNT/DGNT;
  - size constants SIZ_B/SIZ_H/SIZ_W/SIZ_D;
  - the default TIMEOUT constant.
- Sub-module polaris_bus_wdt holds the watchdog counter.
  - Inputs: clear, run, ack.
  - Output: expire.
  - Parameterised by TIMEOUT and TW.

Test Plan:
- Single fetch: isiz_i=2, iadr_i=0x...FF04, mdat_i=0x11112222_33334444, mack_i two cycles after grant -> mcyc_o one cycle after the request, iack_o for 1 cycle, idat_o=0x11112222.
- Single store: dcyc/dstb=1, dwe_i=1, dadr_i=0x1000, ddat_i=0xDEADBEEF, dsiz_i=3, ack in the first grant cycle -> madr_o=0x1000, mwe_o=1, msiz_o=3, dack_o for 1 cycle, iack_o stays 0.
- Contention: ireq and dreq asserted together and held, each acked immediately -> grant order D, I, D, I. Each bus cycle is acked to the correct master; no idle cycle between grants.
- Timeout: TIMEOUT=4, fetch with mack_i held 0 -> iack_o=1 with idat_o=0 and tmo_o=1 on the 4th granted cycle, then IDLE.
- Abandon and reset: drop dcyc_i mid-grant -> mcyc_o=0 the same cycle, no dack_o. Then assert reset_i=0 mid-fetch -> mcyc_o=0 asynchronously; after release, state is IDLE and a new fetch is granted in 1 cycle.
- Timeout collision: TIMEOUT=3 with mack_i arriving exactly on the 3rd cycle -> single ack, tmo_o=0, real data returned.
